// File: rtl/data_memory_responder_if.sv
// Processor data-memory port: request, write data, returned read data and status.
// Latency: none, this is wiring only.
// Backpressure: the responder stalls the processor by holding DataDone low.
interface data_memory_responder_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] DataAddr;
  logic [WORD_SIZE-1:0] DataOut;
  logic                 ReadData;
  logic                 WriteData;
  logic [WORD_SIZE-1:0] DataIn;
  logic                 DataDone;
  logic                 ErrorFlag;

  modport master (
    output DataAddr, DataOut, ReadData, WriteData,
    input  DataIn, DataDone, ErrorFlag
  );

  modport slave (
    input  DataAddr, DataOut, ReadData, WriteData,
    output DataIn, DataDone, ErrorFlag
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed single-port RAM answering the processor data port, one access at a time.
// Latency: LATENCY cycles from acceptance to completion; LATENCY==1 completes at the accepting edge.
// Backpressure: DataDone is low while an access is in flight; the DONE cycle ignores the still-held request.
module data_memory_responder #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 1,
  parameter int CNT_BITS  = 4
) (
  input logic                    Clock,
  input logic                    Reset,
  data_memory_responder_if.slave bus
);

  localparam bit                 SINGLE  = (LATENCY == 1);
  localparam int                 AW      = $clog2(DEPTH);
  localparam logic [WORD_SIZE:0] DEPTH_W = (WORD_SIZE + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_BITS-1:0]  cnt;
  logic [WORD_SIZE-1:0] cap_addr;
  logic [WORD_SIZE-1:0] cap_data;
  logic                 cap_wr;
  logic                 cap_both;
  logic [WORD_SIZE-1:0] data_in_q;
  logic                 err_q;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic                 req;
  logic                 both;
  logic                 acc_en;
  logic                 acc_wr;
  logic                 acc_both;
  logic [WORD_SIZE-1:0] acc_addr;
  logic [WORD_SIZE-1:0] acc_data;
  logic                 in_range;
  logic [AW-1:0]        idx;

  assign req      = bus.ReadData | bus.WriteData;
  assign both     = bus.ReadData & bus.WriteData;
  assign in_range = {1'b0, acc_addr} < DEPTH_W;
  assign idx      = acc_addr[AW-1:0];

  // State register; an asynchronous reset abandons any captured access.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: multi-cycle accesses wait out the counter, then spend one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req && !SINGLE) state_nxt = WAIT;
      WAIT:    if (cnt == CNT_BITS'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: stall flag and selection of the access (live inputs or captured copy) to perform now.
  always_comb begin
    bus.DataDone = (state != WAIT);
    acc_en   = 1'b0;
    acc_wr   = 1'b0;
    acc_both = 1'b0;
    acc_addr = bus.DataAddr;
    acc_data = bus.DataOut;
    case (state)
      IDLE: begin
        if (SINGLE && req) begin
          acc_en   = 1'b1;
          acc_wr   = bus.WriteData;
          acc_both = both;
        end
      end
      WAIT: begin
        if (cnt == CNT_BITS'(1)) begin
          acc_en   = 1'b1;
          acc_wr   = cap_wr;
          acc_both = cap_both;
          acc_addr = cap_addr;
          acc_data = cap_data;
        end
      end
      default: ;
    endcase
  end

  // Capture, countdown, read-data register and sticky error flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt       <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_wr    <= 1'b0;
      cap_both  <= 1'b0;
      data_in_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && !SINGLE && req) begin
        cap_addr <= bus.DataAddr;
        cap_data <= bus.DataOut;
        cap_wr   <= bus.WriteData;
        cap_both <= both;
        cnt      <= CNT_BITS'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_BITS'(1);
      end
      if (acc_en) begin
        if (!acc_wr) data_in_q <= in_range ? mem[idx] : '0;
        if (!in_range || acc_both) err_q <= 1'b1;
      end
    end
  end

  // RAM write port; contents survive reset, out-of-range writes are dropped.
  always_ff @(posedge Clock) begin
    if (acc_en && acc_wr && in_range) mem[idx] <= acc_data;
  end

  assign bus.DataIn    = data_in_q;
  assign bus.ErrorFlag = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder at LATENCY 1 and 4 against a transaction-level memory model.
// Latency: checks stall length, completion edge and the ignored DONE cycle.
// Backpressure: requests are held through the stall and DONE cycle as a stalled pipeline would.
module tb_data_memory_responder;

  logic Clock = 1'b0;
  logic Reset1 = 1'b1;
  logic Reset4 = 1'b1;

  always #5 Clock = ~Clock;

  data_memory_responder_if #(.WORD_SIZE(16)) bus1 ();
  data_memory_responder_if #(.WORD_SIZE(16)) bus4 ();

  data_memory_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(1), .CNT_BITS(4)) dut1 (
    .Clock (Clock),
    .Reset (Reset1),
    .bus   (bus1)
  );

  data_memory_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(4), .CNT_BITS(4)) dut4 (
    .Clock (Clock),
    .Reset (Reset4),
    .bus   (bus4)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: tracked words 0..15, last read value and sticky error per instance.
  logic [15:0] m1 [16];
  logic [15:0] m4 [16];
  logic [15:0] din1, din4;
  logic        err1, err4;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Apply one access to a model memory; returns updated read value and error.
  task automatic model_access(input bit rd, input bit wr, input logic [15:0] addr,
                              input logic [15:0] data, input logic [15:0] mem_in [16],
                              output logic [15:0] mem_out [16],
                              inout logic [15:0] din, inout logic err);
    mem_out = mem_in;
    if (rd && wr) err = 1'b1;
    if (addr >= 16'd256) begin
      err = 1'b1;
      if (!wr) din = 16'h0;
    end else if (wr) begin
      mem_out[addr[3:0]] = data;
    end else begin
      din = mem_in[addr[3:0]];
    end
  endtask

  task automatic acc1(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] data);
    @(negedge Clock);
    bus1.ReadData  = rd;
    bus1.WriteData = wr;
    bus1.DataAddr  = addr;
    bus1.DataOut   = data;
    @(posedge Clock);
    #1;
    model_access(rd, wr, addr, data, m1, m1, din1, err1);
    check("l1_done", bus1.DataDone, 1'b1);
    check("l1_datain", bus1.DataIn, din1);
    check("l1_err", bus1.ErrorFlag, err1);
  endtask

  task automatic idle1();
    @(negedge Clock);
    bus1.ReadData  = 1'b0;
    bus1.WriteData = 1'b0;
  endtask

  // Request held through stall and DONE; address/data lines wander during WAIT.
  task automatic acc4(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] din_before;
    @(negedge Clock);
    bus4.ReadData  = rd;
    bus4.WriteData = wr;
    bus4.DataAddr  = addr;
    bus4.DataOut   = data;
    din_before = din4;
    @(posedge Clock);
    #1;
    check("l4_stall_a", bus4.DataDone, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      bus4.DataOut  = data ^ (16'h0001 | 16'($urandom));
      bus4.DataAddr = 16'($urandom_range(0, 15));
      @(posedge Clock);
      #1;
      check("l4_stall_b", bus4.DataDone, 1'b0);
      check("l4_hold_din", bus4.DataIn, din_before);
    end
    @(posedge Clock);
    #1;
    model_access(rd, wr, addr, data, m4, m4, din4, err4);
    check("l4_done", bus4.DataDone, 1'b1);
    check("l4_datain", bus4.DataIn, din4);
    check("l4_err", bus4.ErrorFlag, err4);
    @(negedge Clock);
    bus4.DataAddr = addr;
    bus4.DataOut  = data;
    @(posedge Clock);
    #1;
    check("l4_once", bus4.DataDone, 1'b1);
    check("l4_once_din", bus4.DataIn, din4);
  endtask

  task automatic idle4();
    @(negedge Clock);
    bus4.ReadData  = 1'b0;
    bus4.WriteData = 1'b0;
  endtask

  task automatic pulse_reset4();
    @(negedge Clock);
    bus4.ReadData  = 1'b0;
    bus4.WriteData = 1'b0;
    Reset4 = 1'b1;
    #1;
    din4 = 16'h0;
    err4 = 1'b0;
    check("rst4_done", bus4.DataDone, 1'b1);
    check("rst4_din", bus4.DataIn, 16'h0);
    check("rst4_err", bus4.ErrorFlag, 1'b0);
    @(negedge Clock);
    Reset4 = 1'b0;
  endtask

  task automatic pulse_reset1();
    @(negedge Clock);
    bus1.ReadData  = 1'b0;
    bus1.WriteData = 1'b0;
    Reset1 = 1'b1;
    #1;
    din1 = 16'h0;
    err1 = 1'b0;
    check("rst1_din", bus1.DataIn, 16'h0);
    check("rst1_err", bus1.ErrorFlag, 1'b0);
    @(negedge Clock);
    Reset1 = 1'b0;
  endtask

  task automatic rand_req(output bit rd, output bit wr, output logic [15:0] addr, output logic [15:0] data);
    int k;
    k    = $urandom_range(0, 11);
    rd   = (k <= 5) || (k == 11);
    wr   = (k >= 6);
    addr = ($urandom_range(0, 9) == 0) ? 16'(256 + $urandom_range(0, 60000)) : 16'($urandom_range(0, 15));
    data = 16'($urandom);
  endtask

  initial begin
    bit          rd, wr;
    logic [15:0] a, d;
    bus1.ReadData = 1'b0; bus1.WriteData = 1'b0; bus1.DataAddr = '0; bus1.DataOut = '0;
    bus4.ReadData = 1'b0; bus4.WriteData = 1'b0; bus4.DataAddr = '0; bus4.DataOut = '0;
    din1 = '0; din4 = '0; err1 = 1'b0; err4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m1[i] = '0;
      m4[i] = '0;
    end

    #2;
    check("reset_done1", bus1.DataDone, 1'b1);
    check("reset_din1", bus1.DataIn, 16'h0);
    check("reset_err1", bus1.ErrorFlag, 1'b0);
    check("reset_done4", bus4.DataDone, 1'b1);
    check("reset_din4", bus4.DataIn, 16'h0);
    check("reset_err4", bus4.ErrorFlag, 1'b0);
    @(negedge Clock);
    Reset1 = 1'b0;
    Reset4 = 1'b0;

    // Known contents for the tracked window.
    for (int i = 0; i < 16; i++) acc1(1'b0, 1'b1, 16'(i), 16'($urandom));
    idle1();
    for (int i = 0; i < 16; i++) acc4(1'b0, 1'b1, 16'(i), 16'($urandom));
    idle4();

    // LATENCY 1: back-to-back write then read of the same word.
    acc1(1'b0, 1'b1, 16'd5, 16'h1234);
    acc1(1'b1, 1'b0, 16'd5, 16'h0);
    check("l1_raw", bus1.DataIn, 16'h1234);
    // Both strobes: treated as a write, DataIn untouched, error raised.
    acc1(1'b1, 1'b1, 16'd9, 16'h0042);
    acc1(1'b1, 1'b0, 16'd9, 16'h0);
    check("l1_both_mem", bus1.DataIn, 16'h0042);
    check("l1_both_err", bus1.ErrorFlag, 1'b1);
    idle1();
    pulse_reset1();

    // LATENCY 4: stalled read, then immediate next read.
    acc4(1'b0, 1'b1, 16'd3, 16'hBEEF);
    acc4(1'b0, 1'b1, 16'd4, 16'h4444);
    acc4(1'b1, 1'b0, 16'd3, 16'h0);
    check("l4_beef", bus4.DataIn, 16'hBEEF);
    acc4(1'b1, 1'b0, 16'd4, 16'h0);
    check("l4_next", bus4.DataIn, 16'h4444);
    // Write data captured at acceptance despite later DataOut changes.
    acc4(1'b0, 1'b1, 16'd7, 16'h00FF);
    acc4(1'b1, 1'b0, 16'd7, 16'h0);
    check("l4_capture", bus4.DataIn, 16'h00FF);
    // Out-of-range read; error stays set through valid accesses.
    acc4(1'b1, 1'b0, 16'd256, 16'h0);
    check("l4_oob_din", bus4.DataIn, 16'h0);
    acc4(1'b1, 1'b0, 16'd3, 16'h0);
    check("l4_sticky", bus4.ErrorFlag, 1'b1);
    idle4();
    pulse_reset4();

    // Reset in the second WAIT cycle aborts a pending write.
    acc4(1'b0, 1'b1, 16'd2, 16'h1111);
    @(negedge Clock);
    bus4.ReadData  = 1'b0;
    bus4.WriteData = 1'b1;
    bus4.DataAddr  = 16'd2;
    bus4.DataOut   = 16'h5555;
    @(posedge Clock);
    @(posedge Clock);
    #2;
    Reset4 = 1'b1;
    #1;
    din4 = 16'h0;
    err4 = 1'b0;
    check("abort_done", bus4.DataDone, 1'b1);
    check("abort_din", bus4.DataIn, 16'h0);
    @(negedge Clock);
    bus4.WriteData = 1'b0;
    Reset4 = 1'b0;
    acc4(1'b1, 1'b0, 16'd2, 16'h0);
    check("abort_mem", bus4.DataIn, 16'h1111);
    idle4();

    // Randomized traffic on both instances, with periodic resets to re-arm the error flag.
    for (int n = 0; n < 60; n++) begin
      rand_req(rd, wr, a, d);
      acc1(rd, wr, a, d);
      if (n % 20 == 19) begin
        idle1();
        pulse_reset1();
      end
    end
    idle1();
    for (int n = 0; n < 40; n++) begin
      rand_req(rd, wr, a, d);
      acc4(rd, wr, a, d);
      if (n % 15 == 14) begin
        idle4();
        pulse_reset4();
      end
    end
    idle4();
    // Final sweep reads of every tracked word.
    for (int i = 0; i < 16; i++) acc1(1'b1, 1'b0, 16'(i), 16'h0);
    idle1();
    for (int i = 0; i < 16; i++) acc4(1'b1, 1'b0, 16'(i), 16'h0);
    idle4();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the processor data-memory port: accepts ReadData/WriteData requests, returns read data on DataIn and drives DataDone low to stall the pipeline while an access is in flight.
- Word-addressed single-port RAM with a fixed parameterised access latency. One outstanding request at a time.
- Includes an accept-once guard so a request the stalled pipeline is still holding is never serviced twice.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- DEPTH, 256, number of words; valid addresses are 0..DEPTH-1.
- LATENCY, 1, cycles from request acceptance to completion; legal range 1..15.
- CNT_BITS, 4, width of the wait counter.

Ports:
- Clock  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high.
- DataAddr  in  WORD_SIZE  word address of the request.
- DataOut  in  WORD_SIZE  write data from the processor.
- ReadData  in  1  read request.
- WriteData  in  1  write request.
- DataIn  out  WORD_SIZE  read data returned to the processor; registered.
- DataDone  out  1  1 = no access pending; 0 = processor must stall. Derived combinationally from state.
- ErrorFlag  out  1  sticky error indicator; cleared only by Reset.

Behaviour:
- Reset (asynchronous): state=IDLE, DataIn=0, ErrorFlag=0, counter=0, DataDone=1. RAM contents are not cleared. Reset during WAIT aborts the captured access; a pending write is not performed.
- Request present = ReadData|WriteData. If both are high, the request is treated as a write and ErrorFlag is set.
- States: IDLE, WAIT, DONE.
- IDLE (DataDone=1), when a request is present at the rising edge:
  - LATENCY==1: the access completes at that edge and the state stays IDLE. Read: DataIn<=mem[DataAddr]. Write: mem[DataAddr]<=DataOut. Back-to-back requests are accepted every cycle.
  - LATENCY>1: capture address, write data and type; counter<=LATENCY-1; go to WAIT.
- IDLE with no request: no change.
- WAIT (DataDone=0): the counter decrements each edge. Inputs are ignored; the captured copy is used. At the edge where counter==1, perform the access (read updates DataIn; write updates RAM) and go to DONE.
  - DataDone is low for exactly LATENCY-1 cycles.
- DONE (DataDone=1): lasts one cycle. Request inputs are ignored, because the pipeline still presents the completed request during this cycle. Go to IDLE unconditionally.
- DataIn holds the last completed read value until the next read completes. Writes never change DataIn. This guarantees DataIn is still valid when the processor's MemoryWait stage samples it one cycle after DONE (or one cycle after acceptance when LATENCY==1).
- Out-of-range address (DataAddr >= DEPTH): a read returns DataIn<=0, a write is dropped, and ErrorFlag is set at the completion edge.
- Read-after-write to the same address in consecutive requests returns the new data. No bypass is needed, since writes complete before the next acceptance.
- Latency from the request cycle to DataIn valid: 1 cycle when LATENCY==1, otherwise LATENCY cycles, plus the DONE cycle before the next acceptance.

Test Plan:
- LATENCY=1: write addr 5 data 0x1234 in cycle 0, read addr 5 in cycle 1 -> DataIn=0x1234 from cycle 2; DataDone stays 1 throughout.
- LATENCY=4: read addr 3 (preloaded 0xBEEF), request held high while stalled -> DataDone=0 for 3 cycles, DataIn=0xBEEF after the 4th edge, DataDone=1 with DONE ignoring the held request (exactly one access counted); a new read of addr 4 in the next cycle is accepted.
- LATENCY=4: write addr 7 data 0x00FF, with DataOut changed to 0xAAAA during WAIT -> the later read of addr 7 returns 0x00FF (the captured value is used).
- Read addr DEPTH (256) -> DataIn=0, ErrorFlag=1 and remains set through later valid accesses until Reset.
- ReadData=WriteData=1, addr 9, DataOut=0x0042 -> mem[9]=0x0042, DataIn unchanged, ErrorFlag=1.
- LATENCY=4: assert Reset during the 2nd WAIT cycle of a write of 0x5555 to addr 2 (previously 0x1111) -> immediately DataDone=1, DataIn=0, state IDLE; a subsequent read of addr 2 returns 0x1111.
